// File: rtl/axis_pkt_gen_pkg.sv
// Shared definitions for the AXI-Stream packet generator: FSM encoding and
// stall-counter width.
package axis_pkt_gen_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int STALL_CNT_WIDTH = 32;

endpackage

// File: rtl/axis_pkt_gen.sv
// AXI-Stream packet generator: programmed count of fixed-length packets with a
// counting payload. Optional stall counter enabled by AXIS_PKT_GEN_STALL_CNT_EN.
module axis_pkt_gen
    import axis_pkt_gen_pkg::*;
#(
    parameter int c_WIDTH     = 8,
    parameter int c_LEN_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [c_LEN_WIDTH-1:0] pkt_len,
    input  logic [c_LEN_WIDTH-1:0] pkt_count,
    input  logic [c_WIDTH-1:0]     seed,
    output logic                   busy,
    output logic                   done,
    output logic [c_WIDTH-1:0]     m_axis_tdata,
    output logic                   m_axis_tvalid,
    input  logic                   m_axis_tready,
    output logic                   m_axis_tlast
`ifdef AXIS_PKT_GEN_STALL_CNT_EN
    ,
    output logic [STALL_CNT_WIDTH-1:0] stall_cnt
`endif
);

    localparam logic [c_LEN_WIDTH-1:0] LEN_ZERO = {c_LEN_WIDTH{1'b0}};
    localparam logic [c_LEN_WIDTH-1:0] LEN_ONE  = {{(c_LEN_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [c_WIDTH-1:0]     DATA_ZERO = {c_WIDTH{1'b0}};
    localparam logic [c_WIDTH-1:0]     DATA_ONE  = {{(c_WIDTH-1){1'b0}}, 1'b1};

    state_t                 state_r;
    state_t                 next_state_s;

    logic [c_LEN_WIDTH-1:0] len_r;
    logic [c_LEN_WIDTH-1:0] count_r;
    logic [c_LEN_WIDTH-1:0] beat_idx_r;
    logic [c_LEN_WIDTH-1:0] pkt_idx_r;
    logic [c_WIDTH-1:0]     tdata_r;
    logic                   tvalid_r;
    logic                   tlast_r;
    logic                   busy_r;
    logic                   done_r;

    logic [c_LEN_WIDTH-1:0] len_s;
    logic [c_LEN_WIDTH-1:0] count_s;
    logic [c_LEN_WIDTH-1:0] beat_idx_s;
    logic [c_LEN_WIDTH-1:0] pkt_idx_s;
    logic [c_WIDTH-1:0]     tdata_s;
    logic                   tvalid_s;
    logic                   tlast_s;
    logic                   busy_s;
    logic                   done_s;

    logic                   start_ok_s;
    logic                   xfer_s;
    logic                   last_beat_s;
    logic                   last_pkt_s;

    assign start_ok_s  = (state_r == ST_IDLE) && start;
    assign xfer_s      = (state_r == ST_SEND) && tvalid_r && m_axis_tready;
    assign last_beat_s = (beat_idx_r == (len_r - LEN_ONE));
    assign last_pkt_s  = (pkt_idx_r == (count_r - LEN_ONE));

    // FSM state register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // FSM next-state logic
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    if ((pkt_len == LEN_ZERO) || (pkt_count == LEN_ZERO)) begin
                        next_state_s = ST_DONE;
                    end else begin
                        next_state_s = ST_SEND;
                    end
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_SEND: begin
                if (xfer_s && last_beat_s && last_pkt_s) begin
                    next_state_s = ST_DONE;
                end else begin
                    next_state_s = ST_SEND;
                end
            end
            ST_DONE: next_state_s = ST_IDLE;
            default: next_state_s = ST_IDLE;
        endcase
    end

    // Next values for the registered outputs, counters and payload; tlast is
    // looked ahead from the next beat index so it is stable with tvalid.
    always_comb begin
        len_s      = len_r;
        count_s    = count_r;
        beat_idx_s = beat_idx_r;
        pkt_idx_s  = pkt_idx_r;
        tdata_s    = tdata_r;
        if (start_ok_s) begin
            len_s      = pkt_len;
            count_s    = pkt_count;
            beat_idx_s = LEN_ZERO;
            pkt_idx_s  = LEN_ZERO;
            tdata_s    = seed;
        end else if (xfer_s) begin
            tdata_s = tdata_r + DATA_ONE;
            if (last_beat_s) begin
                beat_idx_s = LEN_ZERO;
                pkt_idx_s  = pkt_idx_r + LEN_ONE;
            end else begin
                beat_idx_s = beat_idx_r + LEN_ONE;
            end
        end else begin
            tdata_s = tdata_r;
        end
        tvalid_s = (next_state_s == ST_SEND);
        busy_s   = (next_state_s == ST_SEND);
        done_s   = (next_state_s == ST_DONE);
        tlast_s  = tvalid_s && (beat_idx_s == (len_s - LEN_ONE));
    end

    // Datapath and output registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            len_r      <= LEN_ZERO;
            count_r    <= LEN_ZERO;
            beat_idx_r <= LEN_ZERO;
            pkt_idx_r  <= LEN_ZERO;
            tdata_r    <= DATA_ZERO;
            tvalid_r   <= 1'b0;
            tlast_r    <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            len_r      <= len_s;
            count_r    <= count_s;
            beat_idx_r <= beat_idx_s;
            pkt_idx_r  <= pkt_idx_s;
            tdata_r    <= tdata_s;
            tvalid_r   <= tvalid_s;
            tlast_r    <= tlast_s;
            busy_r     <= busy_s;
            done_r     <= done_s;
        end
    end

    assign m_axis_tdata  = tdata_r;
    assign m_axis_tvalid = tvalid_r;
    assign m_axis_tlast  = tlast_r;
    assign busy          = busy_r;
    assign done          = done_r;

`ifdef AXIS_PKT_GEN_STALL_CNT_EN
    localparam logic [STALL_CNT_WIDTH-1:0] STALL_ZERO = {STALL_CNT_WIDTH{1'b0}};
    localparam logic [STALL_CNT_WIDTH-1:0] STALL_ONE  = {{(STALL_CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [STALL_CNT_WIDTH-1:0] STALL_MAX  = {STALL_CNT_WIDTH{1'b1}};

    logic [STALL_CNT_WIDTH-1:0] stall_cnt_r;
    logic [STALL_CNT_WIDTH-1:0] stall_cnt_s;

    // Saturating count of stalled beats within a run, cleared on each new run
    always_comb begin
        stall_cnt_s = stall_cnt_r;
        if (start_ok_s) begin
            stall_cnt_s = STALL_ZERO;
        end else if ((state_r == ST_SEND) && tvalid_r && !m_axis_tready &&
                     (stall_cnt_r != STALL_MAX)) begin
            stall_cnt_s = stall_cnt_r + STALL_ONE;
        end else begin
            stall_cnt_s = stall_cnt_r;
        end
    end

    // Stall counter register
    always_ff @(posedge clk) begin
        if (!rst) begin
            stall_cnt_r <= STALL_ZERO;
        end else begin
            stall_cnt_r <= stall_cnt_s;
        end
    end

    assign stall_cnt = stall_cnt_r;
`endif

endmodule

// File: tb/tb_axis_pkt_gen.sv
// Directed self-checking bench for axis_pkt_gen; checks stall_cnt only when
// AXIS_PKT_GEN_STALL_CNT_EN is defined.
module tb_axis_pkt_gen;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] pkt_len;
    logic [15:0] pkt_count;
    logic [7:0]  seed;
    logic        busy;
    logic        done;
    logic [7:0]  m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic        m_axis_tlast;
`ifdef AXIS_PKT_GEN_STALL_CNT_EN
    logic [31:0] stall_cnt;
`endif

    int n_total;
    int n_bad;

    axis_pkt_gen #(.c_WIDTH(8), .c_LEN_WIDTH(16)) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .pkt_len       (pkt_len),
        .pkt_count     (pkt_count),
        .seed          (seed),
        .busy          (busy),
        .done          (done),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast)
`ifdef AXIS_PKT_GEN_STALL_CNT_EN
        ,
        .stall_cnt     (stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h want=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Run one job and compare every beat against the counting-pattern model.
    task automatic run(input logic [7:0] sd, input int ln, input int ct,
                       input bit toggle, input bit mid_start);
        int          nbeats;
        int          i;
        int          cyc;
        logic [7:0]  exp_data;
        nbeats    = ln * ct;
        i         = 0;
        cyc       = 0;
        seed      = sd;
        pkt_len   = 16'(ln);
        pkt_count = 16'(ct);
        start     = 1'b1;
        m_axis_tready = 1'b1;
        step();
        start = 1'b0;
        while ((i < nbeats) && (cyc < 1000)) begin
            m_axis_tready = toggle ? ((cyc % 2) == 0) : 1'b1;
            if (mid_start && (cyc == 3)) begin
                start     = 1'b1;
                seed      = 8'h55;
                pkt_len   = 16'd2;
                pkt_count = 16'd1;
            end else begin
                start = 1'b0;
            end
            exp_data = sd + 8'(i);
            check("tvalid", {31'd0, m_axis_tvalid}, 32'd1);
            check("busy", {31'd0, busy}, 32'd1);
            check("tdata", {24'd0, m_axis_tdata}, {24'd0, exp_data});
            check("tlast", {31'd0, m_axis_tlast}, ((i % ln) == (ln - 1)) ? 32'd1 : 32'd0);
            check("done_mid", {31'd0, done}, 32'd0);
            if (m_axis_tvalid && m_axis_tready) begin
                i++;
            end
            step();
            cyc++;
        end
        start = 1'b0;
        m_axis_tready = 1'b1;
        if (cyc >= 1000) begin
            check("run_timeout", 32'(cyc), 32'(nbeats));
        end
        if (!toggle) begin
            check("run_cycles", 32'(cyc), 32'(nbeats));
        end
        check("done_pulse", {31'd0, done}, 32'd1);
        check("busy_end", {31'd0, busy}, 32'd0);
        check("tvalid_end", {31'd0, m_axis_tvalid}, 32'd0);
        step();
        check("done_clear", {31'd0, done}, 32'd0);
    endtask

    // Zero-length job: immediate done, never valid, never busy.
    task automatic zero_run(input int ln, input int ct);
        seed      = 8'hAA;
        pkt_len   = 16'(ln);
        pkt_count = 16'(ct);
        start     = 1'b1;
        step();
        start = 1'b0;
        check("zero_done", {31'd0, done}, 32'd1);
        check("zero_busy", {31'd0, busy}, 32'd0);
        check("zero_tvalid", {31'd0, m_axis_tvalid}, 32'd0);
        step();
        check("zero_done_clr", {31'd0, done}, 32'd0);
        check("zero_tvalid2", {31'd0, m_axis_tvalid}, 32'd0);
    endtask

    initial begin
        n_total       = 0;
        n_bad         = 0;
        rst           = 1'b0;
        start         = 1'b0;
        pkt_len       = 16'd0;
        pkt_count     = 16'd0;
        seed          = 8'd0;
        m_axis_tready = 1'b1;
        step();
        step();
        check("rst_tvalid", {31'd0, m_axis_tvalid}, 32'd0);
        check("rst_tlast", {31'd0, m_axis_tlast}, 32'd0);
        check("rst_tdata", {24'd0, m_axis_tdata}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        rst = 1'b1;
        step();

        run(8'h10, 4, 2, 1'b0, 1'b0);
        run(8'h10, 4, 2, 1'b1, 1'b0);
`ifdef AXIS_PKT_GEN_STALL_CNT_EN
        check("stall_cnt", stall_cnt, 32'd7);
`endif
        run(8'hFE, 1, 4, 1'b0, 1'b0);
        zero_run(0, 3);
        zero_run(5, 0);
        run(8'h30, 3, 2, 1'b0, 1'b1);

        // Abort mid-packet, then restart from a fresh seed
        seed      = 8'h20;
        pkt_len   = 16'd4;
        pkt_count = 16'd1;
        start     = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        check("pre_rst_tdata", {24'd0, m_axis_tdata}, 32'h22);
        rst = 1'b0;
        step();
        check("abort_tvalid", {31'd0, m_axis_tvalid}, 32'd0);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        check("abort_tdata", {24'd0, m_axis_tdata}, 32'd0);
        rst = 1'b1;
        step();
        check("abort_done2", {31'd0, done}, 32'd0);
        check("abort_tvalid2", {31'd0, m_axis_tvalid}, 32'd0);
        run(8'h80, 2, 1, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
